// File: rtl/tftlcd_axil_pkg.sv
// Shared constants and helpers for the TFT-LCD AXI4-Lite register slave.
package tftlcd_axil_pkg;

    localparam logic [3:0] ADDR_CTRL  = 4'h0;
    localparam logic [3:0] ADDR_DATA  = 4'h4;
    localparam logic [3:0] ADDR_CFG   = 4'h8;
    localparam logic [3:0] ADDR_COLOR = 4'hC;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_BUSY = 31;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte-lane merge of a write word into the current register value.
    function automatic logic [31:0] wstrb_merge(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (wstrb[k]) res[8*k +: 8] = wdata[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/tftlcd_axil_slave.sv
// AXI4-Lite register slave for the TFT-LCD peripheral; DATA writes feed the LCD bus engine.
// Define TFTLCD_DATA_SLVERR_EN to reject DATA writes with SLVERR while CTRL[0] is clear.
module tftlcd_axil_slave
    import tftlcd_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            lcd_valid,
    input  logic                            lcd_ready,
    output logic [31:0]                     lcd_data,
    output logic [31:0]                     lcd_ctrl,
    output logic [31:0]                     lcd_cfg
);

    logic        aw_held, w_held, bvalid_q, awready_q, wready_q;
    logic        arready_q, rvalid_q, lcd_valid_q;
    logic [1:0]  aw_sel, bresp_q;
    logic [31:0] w_data, rdata_q, lcd_data_q;
    logic [3:0]  w_strb;
    logic [31:0] ctrl_q, data_q, cfg_q, color_q;

    logic        aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic        sel_data, data_err, push_req, commit;
    logic        aw_held_nxt, w_held_nxt, bvalid_nxt, rvalid_nxt;
    logic [31:0] wr_cur, merged, rd_val, ctrl_rd;
    logic        unused_inputs;

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_fire = S_AXI_AWVALID && awready_q;
    assign w_fire  = S_AXI_WVALID && wready_q;
    assign b_fire  = bvalid_q && S_AXI_BREADY;
    assign ar_fire = S_AXI_ARVALID && arready_q;
    assign r_fire  = rvalid_q && S_AXI_RREADY;

    assign sel_data = (aw_sel == ADDR_DATA[3:2]);
`ifdef TFTLCD_DATA_SLVERR_EN
    assign data_err = sel_data && !ctrl_q[CTRL_EN];
`else
    assign data_err = 1'b0;
`endif
    assign push_req = sel_data && (|w_strb) && !data_err;
    // A DATA push waits for the single-word slot unless the engine frees it this cycle.
    assign commit   = aw_held && w_held && !bvalid_q && !(push_req && lcd_valid_q && !lcd_ready);

    assign aw_held_nxt = commit ? 1'b0 : (aw_fire ? 1'b1 : aw_held);
    assign w_held_nxt  = commit ? 1'b0 : (w_fire ? 1'b1 : w_held);
    assign bvalid_nxt  = commit ? 1'b1 : (b_fire ? 1'b0 : bvalid_q);
    assign rvalid_nxt  = ar_fire ? 1'b1 : (r_fire ? 1'b0 : rvalid_q);

    always_comb begin
        ctrl_rd            = ctrl_q;
        ctrl_rd[CTRL_BUSY] = lcd_valid_q;
        unique case (aw_sel)
            ADDR_CTRL[3:2]: wr_cur = ctrl_q;
            ADDR_DATA[3:2]: wr_cur = data_q;
            ADDR_CFG[3:2]:  wr_cur = cfg_q;
            default:        wr_cur = color_q;
        endcase
        unique case (S_AXI_ARADDR[3:2])
            ADDR_CTRL[3:2]: rd_val = ctrl_rd;
            ADDR_DATA[3:2]: rd_val = data_q;
            ADDR_CFG[3:2]:  rd_val = cfg_q;
            default:        rd_val = color_q;
        endcase
    end

    assign merged = wstrb_merge(wr_cur, w_data, w_strb);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; this is what makes a same-cycle read return the pre-write value.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            bvalid_q    <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            lcd_valid_q <= 1'b0;
            aw_sel      <= '0;
            bresp_q     <= RESP_OKAY;
            w_data      <= '0;
            w_strb      <= '0;
            rdata_q     <= '0;
            lcd_data_q  <= '0;
            ctrl_q      <= '0;
            data_q      <= '0;
            cfg_q       <= '0;
            color_q     <= '0;
        end else begin
            aw_held   <= aw_held_nxt;
            w_held    <= w_held_nxt;
            bvalid_q  <= bvalid_nxt;
            awready_q <= !aw_held_nxt && !bvalid_nxt;
            wready_q  <= !w_held_nxt && !bvalid_nxt;
            rvalid_q  <= rvalid_nxt;
            arready_q <= !rvalid_nxt;

            if (aw_fire) aw_sel <= S_AXI_AWADDR[3:2];
            if (w_fire) begin
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (ar_fire) rdata_q <= rd_val;

            if (commit) begin
                bresp_q <= data_err ? RESP_SLVERR : RESP_OKAY;
                unique case (aw_sel)
                    ADDR_CTRL[3:2]: begin
                        ctrl_q            <= merged;
                        ctrl_q[CTRL_BUSY] <= 1'b0;
                    end
                    ADDR_DATA[3:2]: if (!data_err) data_q <= merged;
                    ADDR_CFG[3:2]:  cfg_q <= merged;
                    default:        color_q <= merged;
                endcase
            end

            if (commit && push_req) begin
                lcd_valid_q <= 1'b1;
                lcd_data_q  <= merged;
            end else if (lcd_valid_q && lcd_ready) begin
                lcd_valid_q <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign lcd_valid     = lcd_valid_q;
    assign lcd_data      = lcd_data_q;
    assign lcd_ctrl      = ctrl_q;
    assign lcd_cfg       = cfg_q;

endmodule

// File: tb/tb_tftlcd_axil_slave.sv
// Self-checking bench for tftlcd_axil_slave: directed vector table, corner sequences, random traffic vs model.
module tb_tftlcd_axil_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        lcd_valid, lcd_ready;
    logic [31:0] lcd_data, lcd_ctrl, lcd_cfg;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tftlcd_axil_slave dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .lcd_valid(lcd_valid), .lcd_ready(lcd_ready), .lcd_data(lcd_data),
        .lcd_ctrl(lcd_ctrl), .lcd_cfg(lcd_cfg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
        bit aw_hs, w_hs, b_hs, done;
        int n;
        done = 0;
        n = 0;
        resp = 2'bxx;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!done && n < 100) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            if (b_hs) resp = bresp;
            tick();
            n++;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
            if (b_hs) done = 1;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        if (!done) check("write_timeout", 32'(done), 32'd1);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        bit ar_hs, r_hs, done;
        int n;
        done = 0;
        n = 0;
        data = 'x;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        while (!done && n < 100) begin
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (r_hs) begin
                data = rdata;
                if (rresp !== 2'b00) check("rresp", 32'(rresp), 32'd0);
            end
            tick();
            n++;
            if (ar_hs) arvalid = 1'b0;
            if (r_hs) done = 1;
        end
        arvalid = 1'b0; rready = 1'b0;
        if (!done) check("read_timeout", 32'(done), 32'd1);
    endtask

    // Behavioural model: register array plus the last word handed to the LCD engine.
    logic [31:0] mdl [4];
    logic [31:0] mdl_lcd;

    function automatic logic [1:0] model_write(input logic [1:0] sel, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] m;
        m = mdl[sel];
        for (int k = 0; k < 4; k++) if (s[k]) m[8*k +: 8] = d[8*k +: 8];
`ifdef TFTLCD_DATA_SLVERR_EN
        if (sel == 2'd1 && !mdl[0][0]) return 2'b10;
`endif
        if (sel == 2'd0) m[31] = 1'b0;
        mdl[sel] = m;
        if (sel == 2'd1 && s != 4'd0) mdl_lcd = m;
        return 2'b00;
    endfunction

    typedef struct {
        bit          is_read;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [31:0] d1, d2;

        rst = 1'b1;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = '0; wstrb = '0; lcd_ready = 0;

        vecs[0]  = '{0, 4'h0, 32'h1,        4'hF, 32'h0};
        vecs[1]  = '{0, 4'h4, 32'h2,        4'hF, 32'h0};
        vecs[2]  = '{0, 4'h8, 32'h3,        4'hF, 32'h0};
        vecs[3]  = '{0, 4'hC, 32'h4,        4'hF, 32'h0};
        vecs[4]  = '{1, 4'h0, 32'h0,        4'h0, 32'h80000001};
        vecs[5]  = '{1, 4'h4, 32'h0,        4'h0, 32'h2};
        vecs[6]  = '{1, 4'h8, 32'h0,        4'h0, 32'h3};
        vecs[7]  = '{1, 4'hC, 32'h0,        4'h0, 32'h4};
        vecs[8]  = '{0, 4'h8, 32'h0,        4'hF, 32'h0};
        vecs[9]  = '{0, 4'h8, 32'hAABBCCDD, 4'h5, 32'h0};
        vecs[10] = '{1, 4'h8, 32'h0,        4'h0, 32'h00BB00DD};

        // Reset state
        tick(); tick();
        check("reset_ready", 32'({awready, wready, arready}), 32'd0);
        check("reset_valid", 32'({bvalid, rvalid, lcd_valid, bresp, rresp}), 32'd0);
        check("reset_data", rdata | lcd_data | lcd_ctrl | lcd_cfg, 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_reset", 32'({awready, wready, arready}), 32'd7);

        // Directed table (lcd_ready held low)
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].is_read) begin
                axi_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            end else begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
                check($sformatf("vec%0d_bresp", i), 32'(resp), 32'd0);
            end
        end
        check("table_lcd_data", lcd_data, 32'h2);
        check("table_lcd_valid", 32'(lcd_valid), 32'd1);
        check("table_lcd_cfg", lcd_cfg, 32'h00BB00DD);

        // Read accepted in the commit cycle returns the pre-write value
        awaddr = 4'h8; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; araddr = 4'h8; arvalid = 1;
        tick();
        arvalid = 0;
        check("same_cycle_rd_valid", 32'({rvalid, bvalid}), 32'd3);
        check("same_cycle_rd_old", rdata, 32'h00BB00DD);
        rready = 1; bready = 1;
        tick();
        rready = 0; bready = 0;
        axi_read(4'h8, rd);
        check("same_cycle_rd_new", rd, 32'h12345678);

        // W three cycles ahead of AW
        awaddr = 4'hC; wdata = 32'hC0FFEE01; wstrb = 4'hF; wvalid = 1;
        tick();
        wvalid = 0;
        tick(); tick();
        check("w_only_no_commit", 32'(bvalid), 32'd0);
        awvalid = 1;
        tick();
        awvalid = 0;
        check("aw_hs_no_bvalid_yet", 32'(bvalid), 32'd0);
        tick();
        check("bvalid_one_after_aw", 32'(bvalid), 32'd1);

        // BREADY low for 10 cycles with a second write waiting
        awaddr = 4'hC; wdata = 32'hC0FFEE02; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bstall_state", 32'({bvalid, awready, wready}), 32'b100);
        end
        bready = 1;
        tick();
        bready = 0;
        check("bstall_released", 32'({bvalid, awready, wready}), 32'b011);
        tick();
        awvalid = 0; wvalid = 0;
        check("second_no_bvalid_yet", 32'(bvalid), 32'd0);
        tick();
        check("second_bvalid", 32'({bvalid, bresp}), 32'b100);
        bready = 1;
        tick();
        bready = 0;
        axi_read(4'hC, rd);
        check("color_second_value", rd, 32'hC0FFEE02);

        // Back-to-back DATA writes against a stalled LCD engine
        lcd_ready = 1;
        tick();
        lcd_ready = 0;
        check("lcd_drained", 32'(lcd_valid), 32'd0);
        d1 = 32'hDA7A0001;
        d2 = 32'hDA7A0002;
        axi_write(4'h4, d1, 4'hF, resp);
        check("d1_bresp", 32'(resp), 32'd0);
        check("d1_lcd", lcd_data, d1);
        awaddr = 4'h4; wdata = d2; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("d2_withheld", 32'({bvalid, lcd_valid}), 32'b01);
            check("d2_lcd_still_d1", lcd_data, d1);
        end
        lcd_ready = 1;
        tick();
        lcd_ready = 0;
        check("d2_pushed", lcd_data, d2);
        check("d2_valid_bvalid", 32'({lcd_valid, bvalid}), 32'b11);
        bready = 1;
        tick();
        bready = 0;
        axi_read(4'h4, rd);
        check("data_reg_d2", rd, d2);

        // DATA write with CTRL[0] cleared
        lcd_ready = 1;
        tick();
        lcd_ready = 0;
        axi_write(4'h0, 32'h0, 4'hF, resp);
        check("ctrl_clear_bresp", 32'(resp), 32'd0);
        check("lcd_ctrl_zero", lcd_ctrl, 32'd0);
        axi_write(4'h4, 32'h55, 4'hF, resp);
        axi_read(4'h4, rd);
`ifdef TFTLCD_DATA_SLVERR_EN
        check("slverr_bresp", 32'(resp), 32'd2);
        check("slverr_no_push", 32'(lcd_valid), 32'd0);
        check("slverr_data_kept", rd, d2);
`else
        check("noerr_bresp", 32'(resp), 32'd0);
        check("noerr_push", 32'(lcd_valid), 32'd1);
        check("noerr_lcd_data", lcd_data, 32'h55);
        check("noerr_data_reg", rd, 32'h55);
`endif

        // Zero-strobe DATA write commits without pushing
        lcd_ready = 1;
        tick();
        lcd_ready = 0;
        axi_write(4'h0, 32'h1, 4'hF, resp);
        axi_write(4'h4, 32'hFFFFFFFF, 4'h0, resp);
        check("zero_strb_bresp", 32'(resp), 32'd0);
        check("zero_strb_no_push", 32'(lcd_valid), 32'd0);

        // Randomised traffic against the model, engine always ready
        lcd_ready = 1;
        mdl[0] = 32'h0; mdl[1] = 32'h0; mdl[2] = 32'h0; mdl[3] = 32'h0; mdl_lcd = 32'h0;
        for (int s = 0; s < 4; s++) begin
            logic [31:0] v;
            logic [1:0]  e;
            v = $urandom;
            if (s == 0) v[0] = 1'b1;
            e = model_write(2'(s), v, 4'hF);
            axi_write({2'(s), 2'b00}, v, 4'hF, resp);
            check("rand_init_bresp", 32'(resp), 32'(e));
        end
        for (int i = 0; i < 80; i++) begin
            logic [1:0]  sel, e;
            logic [31:0] v;
            logic [3:0]  st;
            sel = 2'($urandom_range(0, 3));
            v   = $urandom;
            st  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                e = model_write(sel, v, st);
                axi_write({sel, 2'($urandom_range(0, 3))}, v, st, resp);
                check("rand_bresp", 32'(resp), 32'(e));
                if (sel == 2'd1) check("rand_lcd_data", lcd_data, mdl_lcd);
            end else begin
                axi_read({sel, 2'($urandom_range(0, 3))}, rd);
                check("rand_rdata", rd, mdl[sel]);
            end
        end

        // Reset mid-transaction drops everything
        awaddr = 4'h4; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1; lcd_ready = 0;
        tick();
        rst = 1'b1;
        awvalid = 0; wvalid = 0;
        tick();
        check("midreset_clear", 32'({bvalid, lcd_valid, awready, rvalid}), 32'd0);
        rst = 1'b0;
        tick(); tick();
        check("midreset_no_response", 32'({bvalid, lcd_valid}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
